// File: rtl/rv32_pkg.sv
// Shared RV32 front-end types: PC width, prediction metadata carried beside the
// IF/ID and ID/EX registers, and the branch-resolve FSM encoding.
package rv32_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned PC_INC = 4;

    typedef struct packed {
        logic            v;
        logic [XLEN-1:0] pc;
        logic            pred;
        logic [XLEN-1:0] ptgt;
    } meta_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } bru_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves EX-stage control flow against fetch-time BTB predictions: issues a
// one-cycle flush/redirect on mispredict and trains the BTB with the outcome.
module branch_resolve_unit
    import rv32_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    input  logic [XLEN-1:0]  if_pc,
    input  logic             if_predicted,
    input  logic [XLEN-1:0]  if_pred_target,
    input  logic             stall,
    input  logic             ex_valid,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_is_branch,
    input  logic             ex_taken,
    input  logic [XLEN-1:0]  ex_target,
    output logic             flush,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             upd_valid,
    output logic [XLEN-1:0]  upd_pc,
    output logic [XLEN-1:0]  upd_target,
    output logic             upd_taken,
    output logic             meta_err,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    bru_state_e      state_q, state_d;
    meta_t           s_id_q, s_id_d;
    meta_t           s_ex_q, s_ex_d;
    logic [XLEN-1:0] redirect_q, redirect_d;
    logic            upd_valid_q, upd_valid_d;
    logic [XLEN-1:0] upd_pc_q, upd_pc_d;
    logic [XLEN-1:0] upd_target_q, upd_target_d;
    logic            upd_taken_q, upd_taken_d;
    logic            meta_err_q, meta_err_d;

    logic            eval;
    logic            meta_hit;
    logic            pred_eff;
    logic            mispredict;
    logic            train;
    logic [XLEN-1:0] seq_pc;

    // FSM next-state, evaluation and redirect target selection
    always_comb begin
        state_d    = state_q;
        redirect_d = redirect_q;
        eval       = 1'b0;
        mispredict = 1'b0;
        meta_hit   = s_ex_q.v && (s_ex_q.pc == ex_pc);
        pred_eff   = meta_hit && s_ex_q.pred;
        seq_pc     = ex_pc + XLEN'(PC_INC);

        case (state_q)
            ST_RUN: begin
                eval = ex_valid && !stall;
                if (eval) begin
                    if (ex_is_branch && ex_taken &&
                        (!pred_eff || (s_ex_q.ptgt != ex_target))) begin
                        mispredict = 1'b1;
                        redirect_d = ex_target;
                    end else if (pred_eff && (!ex_is_branch || !ex_taken)) begin
                        // Predicted-taken that fell through, or a BTB alias on a non-branch
                        mispredict = 1'b1;
                        redirect_d = seq_pc;
                    end
                end
                if (mispredict) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Metadata pipe: flush clears both stages and overrides stall
    always_comb begin
        s_id_d = s_id_q;
        s_ex_d = s_ex_q;
        if (state_q == ST_FLUSH) begin
            s_id_d = '0;
            s_ex_d = '0;
        end else if (!stall) begin
            s_ex_d      = s_id_q;
            s_id_d.v    = if_valid;
            s_id_d.pc   = if_pc;
            s_id_d.pred = if_predicted;
            s_id_d.ptgt = if_pred_target;
        end
    end

    // BTB training and sticky metadata error
    always_comb begin
        train        = eval && (ex_is_branch || pred_eff);
        upd_valid_d  = train;
        upd_pc_d     = upd_pc_q;
        upd_target_d = upd_target_q;
        upd_taken_d  = upd_taken_q;
        meta_err_d   = meta_err_q || (eval && !meta_hit);
        if (train) begin
            upd_pc_d     = ex_pc;
            upd_target_d = ex_target;
            upd_taken_d  = ex_is_branch && ex_taken;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_id_q       <= '0;
            s_ex_q       <= '0;
            redirect_q   <= '0;
            upd_valid_q  <= 1'b0;
            upd_pc_q     <= '0;
            upd_target_q <= '0;
            upd_taken_q  <= 1'b0;
            meta_err_q   <= 1'b0;
        end else begin
            s_id_q       <= s_id_d;
            s_ex_q       <= s_ex_d;
            redirect_q   <= redirect_d;
            upd_valid_q  <= upd_valid_d;
            upd_pc_q     <= upd_pc_d;
            upd_target_q <= upd_target_d;
            upd_taken_q  <= upd_taken_d;
            meta_err_q   <= meta_err_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (eval && ex_is_branch),
        .count (branch_count)
    );

    sat_counter #(.W(CNT_W)) u_mispredict_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mispredict),
        .count (mispredict_count)
    );

    assign flush       = (state_q == ST_FLUSH);
    assign redirect_pc = redirect_q;
    assign upd_valid   = upd_valid_q;
    assign upd_pc      = upd_pc_q;
    assign upd_target  = upd_target_q;
    assign upd_taken   = upd_taken_q;
    assign meta_err    = meta_err_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed transactions push expected
// flush/training events; a negedge monitor pops and compares them.
module tb_branch_resolve_unit;

    localparam int unsigned XW = 32;
    localparam int unsigned CW = 32;

    typedef struct packed {
        logic [XW-1:0] pc;
        logic [XW-1:0] tgt;
        logic          tk;
    } upd_exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_valid = 1'b0;
    logic [XW-1:0] if_pc = '0;
    logic          if_predicted = 1'b0;
    logic [XW-1:0] if_pred_target = '0;
    logic          stall = 1'b0;
    logic          ex_valid = 1'b0;
    logic [XW-1:0] ex_pc = '0;
    logic          ex_is_branch = 1'b0;
    logic          ex_taken = 1'b0;
    logic [XW-1:0] ex_target = '0;
    logic          flush;
    logic [XW-1:0] redirect_pc;
    logic          upd_valid;
    logic [XW-1:0] upd_pc;
    logic [XW-1:0] upd_target;
    logic          upd_taken;
    logic          meta_err;
    logic [CW-1:0] branch_count;
    logic [CW-1:0] mispredict_count;

    logic [XW-1:0] flush_exp[$];
    upd_exp_t      upd_exp[$];
    int            errors = 0;
    int            checks = 0;

    branch_resolve_unit #(.CNT_W(CW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_valid         (if_valid),
        .if_pc            (if_pc),
        .if_predicted     (if_predicted),
        .if_pred_target   (if_pred_target),
        .stall            (stall),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_is_branch     (ex_is_branch),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .flush            (flush),
        .redirect_pc      (redirect_pc),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_target       (upd_target),
        .upd_taken        (upd_taken),
        .meta_err         (meta_err),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every flush or training strobe must match the head of its queue
    always @(negedge clk) begin
        if (rst_n) begin
            if (flush) begin
                if (flush_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_flush: got redirect 0x%0h expected no flush", redirect_pc);
                end else begin
                    chk("redirect_pc", 64'(redirect_pc), 64'(flush_exp.pop_front()));
                end
            end
            if (upd_valid) begin
                if (upd_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_update: got pc 0x%0h expected no update", upd_pc);
                end else begin
                    upd_exp_t e;
                    e = upd_exp.pop_front();
                    chk("upd_pc", 64'(upd_pc), 64'(e.pc));
                    chk("upd_target", 64'(upd_target), 64'(e.tgt));
                    chk("upd_taken", 64'(upd_taken), 64'(e.tk));
                end
            end
        end
    end

    // Fetch one instruction, let it reach EX two cycles later, then resolve it
    task automatic issue(input string nm, input logic [XW-1:0] pc, input logic pred,
                         input logic [XW-1:0] ptgt, input logic br, input logic tk,
                         input logic [XW-1:0] tgt, input logic xf, input logic [XW-1:0] xred,
                         input logic xu, input logic xutk, input int xbc, input int xmc);
        upd_exp_t e;
        if_valid = 1'b1; if_pc = pc; if_predicted = pred; if_pred_target = ptgt;
        step();
        if_valid = 1'b0; if_predicted = 1'b0;
        step();
        ex_valid = 1'b1; ex_pc = pc; ex_is_branch = br; ex_taken = tk; ex_target = tgt;
        if (xf) flush_exp.push_back(xred);
        if (xu) begin
            e.pc = pc; e.tgt = tgt; e.tk = xutk;
            upd_exp.push_back(e);
        end
        step();
        ex_valid = 1'b0;
        chk({nm, " branch_count"}, 64'(branch_count), 64'(xbc));
        chk({nm, " mispredict_count"}, 64'(mispredict_count), 64'(xmc));
        step();
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        upd_exp_t e;
        step();
        step();
        chk("reset flush", 64'(flush), 64'd0);
        chk("reset upd_valid", 64'(upd_valid), 64'd0);
        chk("reset meta_err", 64'(meta_err), 64'd0);
        chk("reset redirect_pc", 64'(redirect_pc), 64'd0);
        chk("reset branch_count", 64'(branch_count), 64'd0);
        chk("reset mispredict_count", 64'(mispredict_count), 64'd0);
        rst_n = 1'b1;
        step();

        issue("correct", 32'h100, 1'b1, 32'h200, 1'b1, 1'b1, 32'h200,
              1'b0, 32'h0, 1'b1, 1'b1, 1, 0);
        issue("cold_taken", 32'h40, 1'b0, 32'h0, 1'b1, 1'b1, 32'h80,
              1'b1, 32'h80, 1'b1, 1'b1, 2, 1);
        issue("not_taken_wrap", 32'hFFFF_FFFC, 1'b1, 32'h1000, 1'b1, 1'b0, 32'h1000,
              1'b1, 32'h0, 1'b1, 1'b0, 3, 2);
        issue("wrong_target", 32'h200, 1'b1, 32'h300, 1'b1, 1'b1, 32'h340,
              1'b1, 32'h340, 1'b1, 1'b1, 4, 3);
        chk("meta_err clean", 64'(meta_err), 64'd0);

        // Stall with an EX instruction: nothing resolves until release
        if_valid = 1'b1; if_pc = 32'h500; if_predicted = 1'b0; if_pred_target = 32'h0;
        step();
        if_valid = 1'b0;
        step();
        ex_valid = 1'b1; ex_pc = 32'h500; ex_is_branch = 1'b1; ex_taken = 1'b0;
        ex_target = 32'h540; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall upd_valid", 64'(upd_valid), 64'd0);
            chk("stall branch_count", 64'(branch_count), 64'd4);
        end
        stall = 1'b0;
        e.pc = 32'h500; e.tgt = 32'h540; e.tk = 1'b0;
        upd_exp.push_back(e);
        step();
        ex_valid = 1'b0;
        chk("stall release branch_count", 64'(branch_count), 64'd5);
        chk("stall release mispredict_count", 64'(mispredict_count), 64'd3);
        step();
        step();

        // EX PC with no tracked metadata: prediction treated as not-taken
        ex_valid = 1'b1; ex_pc = 32'h900; ex_is_branch = 1'b1; ex_taken = 1'b1;
        ex_target = 32'h940;
        flush_exp.push_back(32'h940);
        e.pc = 32'h900; e.tgt = 32'h940; e.tk = 1'b1;
        upd_exp.push_back(e);
        step();
        ex_valid = 1'b0;
        chk("meta_err set", 64'(meta_err), 64'd1);
        chk("meta branch_count", 64'(branch_count), 64'd6);
        chk("meta mispredict_count", 64'(mispredict_count), 64'd4);
        step();
        step();
        chk("meta_err sticky", 64'(meta_err), 64'd1);

        // Alias on a non-branch, then async reset during the flush cycle
        if_valid = 1'b1; if_pc = 32'h10; if_predicted = 1'b1; if_pred_target = 32'h80;
        step();
        if_valid = 1'b0; if_predicted = 1'b0;
        step();
        ex_valid = 1'b1; ex_pc = 32'h10; ex_is_branch = 1'b0; ex_taken = 1'b0;
        ex_target = 32'h14;
        flush_exp.push_back(32'h14);
        e.pc = 32'h10; e.tgt = 32'h14; e.tk = 1'b0;
        upd_exp.push_back(e);
        step();
        ex_valid = 1'b0;
        chk("alias flush", 64'(flush), 64'd1);
        chk("alias branch_count", 64'(branch_count), 64'd6);
        chk("alias mispredict_count", 64'(mispredict_count), 64'd5);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async reset flush", 64'(flush), 64'd0);
        chk("async reset upd_valid", 64'(upd_valid), 64'd0);
        chk("async reset meta_err", 64'(meta_err), 64'd0);
        chk("async reset branch_count", 64'(branch_count), 64'd0);
        chk("async reset mispredict_count", 64'(mispredict_count), 64'd0);
        chk("async reset redirect_pc", 64'(redirect_pc), 64'd0);
        step();

        chk("flush queue drained", 64'(flush_exp.size()), 64'd0);
        chk("update queue drained", 64'(upd_exp.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
